// File: rtl/pe_seq_ctrl_if.sv
// Bundle of the scheduler, weight-buffer, image-stream, PE and result ports
// around the PE sequencer. The controller connects through the slave modport.
interface pe_seq_ctrl_if #(
   parameter int IMG_W  = 24,
   parameter int WGT_W  = 36,
   parameter int PSUM_W = 16,
   parameter int EXP_W  = 5,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
);
   // job configuration / status
   logic              cfg_start;
   logic [ADDR_W-1:0] cfg_wgt_addr;
   logic [CNT_W-1:0]  cfg_len;
   logic [EXP_W-1:0]  cfg_exp_bias;
   logic [PSUM_W-1:0] cfg_psum_init;
   logic              busy;
   logic              done;
   // weight buffer read port
   logic              wbuf_rd_en;
   logic [ADDR_W-1:0] wbuf_addr;
   logic [WGT_W-1:0]  wbuf_rdata;
   // image stream
   logic              img_valid;
   logic [IMG_W-1:0]  img_data;
   logic              img_ready;
   // PE side
   logic              pe_en;
   logic [EXP_W-1:0]  pe_exp_bias;
   logic [WGT_W-1:0]  pe_weight;
   logic [IMG_W-1:0]  pe_image;
   logic [PSUM_W-1:0] pe_psum;
   logic [PSUM_W-1:0] pe_psum_out;
   // result port
   logic              out_valid;
   logic [PSUM_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  cfg_start, cfg_wgt_addr, cfg_len, cfg_exp_bias, cfg_psum_init,
      input  wbuf_rdata, img_valid, img_data, pe_psum_out, out_ready,
      output busy, done, wbuf_rd_en, wbuf_addr, img_ready,
      output pe_en, pe_exp_bias, pe_weight, pe_image, pe_psum,
      output out_valid, out_data
   );

   modport master (
      output cfg_start, cfg_wgt_addr, cfg_len, cfg_exp_bias, cfg_psum_init,
      output wbuf_rdata, img_valid, img_data, pe_psum_out, out_ready,
      input  busy, done, wbuf_rd_en, wbuf_addr, img_ready,
      input  pe_en, pe_exp_bias, pe_weight, pe_image, pe_psum,
      input  out_valid, out_data
   );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one SD4 MAC PE: fetch the job's weight word, latch it into the
// PE, stream cfg_len image words through it with psum fed back, then present
// the final partial sum on a valid/ready port.
// Strobes that belong to a state (rd_en, img_ready, out_valid, busy) are
// registered from the next state so they line up with the state itself.
// The weight word arrives the cycle after the read strobe (the WLD cycle) and
// is captured at the end of WLD together with pe_en, so the PE sees pe_en
// with pe_weight already stable.
module pe_seq_ctrl #(
   parameter int IMG_W  = 24,
   parameter int WGT_W  = 36,
   parameter int PSUM_W = 16,
   parameter int EXP_W  = 5,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8,
   parameter int PE_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   pe_seq_ctrl_if.slave bus
);
   localparam int WC_W = $clog2(PE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRD, S_WLD, S_STRM, S_WAIT, S_OUT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [WC_W-1:0]   wcnt_q, wcnt_d;
   logic [PSUM_W-1:0] acc_q, acc_d;
   logic [EXP_W-1:0]  bias_q, bias_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wbuf_rd_en_q, wbuf_rd_en_d;
   logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
   logic              img_ready_q, img_ready_d;
   logic              pe_en_q, pe_en_d;
   logic [EXP_W-1:0]  pe_exp_bias_q, pe_exp_bias_d;
   logic [WGT_W-1:0]  pe_weight_q, pe_weight_d;
   logic [IMG_W-1:0]  pe_image_q, pe_image_d;
   logic [PSUM_W-1:0] pe_psum_q, pe_psum_d;
   logic              out_valid_q, out_valid_d;
   logic [PSUM_W-1:0] out_data_q, out_data_d;

   // Next-state, counter and output computation.
   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      wcnt_d        = wcnt_q;
      acc_d         = acc_q;
      bias_d        = bias_q;
      wbuf_addr_d   = wbuf_addr_q;
      pe_exp_bias_d = pe_exp_bias_q;
      pe_weight_d   = pe_weight_q;
      pe_image_d    = pe_image_q;
      pe_psum_d     = pe_psum_q;
      pe_en_d       = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cfg_start) begin
               wbuf_addr_d = bus.cfg_wgt_addr;
               rem_d       = bus.cfg_len;
               bias_d      = bus.cfg_exp_bias;
               acc_d       = bus.cfg_psum_init;
               state_d     = S_WRD;
            end
         end
         S_WRD: state_d = S_WLD;
         S_WLD: begin
            // read data is valid this cycle; hand it to the PE with its enable
            pe_weight_d   = bus.wbuf_rdata;
            pe_exp_bias_d = bias_q;
            pe_en_d       = 1'b1;
            state_d       = (rem_q == '0) ? S_OUT : S_STRM;
         end
         S_STRM: begin
            if (bus.img_valid && img_ready_q) begin
               pe_image_d = bus.img_data;
               pe_psum_d  = acc_q;
               rem_d      = rem_q - CNT_W'(1);
               wcnt_d     = WC_W'(PE_LAT);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            wcnt_d = wcnt_q - WC_W'(1);
            // last wait cycle: PE result is valid, fold it back into acc
            if (wcnt_q == WC_W'(1)) begin
               acc_d   = bus.pe_psum_out;
               state_d = (rem_q == '0) ? S_OUT : S_STRM;
            end
         end
         S_OUT: begin
            if (out_valid_q && bus.out_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d       = (state_d != S_IDLE);
      wbuf_rd_en_d = (state_d == S_WRD);
      img_ready_d  = (state_d == S_STRM);
      out_valid_d  = (state_d == S_OUT);
      out_data_d   = (state_d == S_OUT) ? acc_d : out_data_q;
   end

   // State, datapath and registered outputs; reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rem_q         <= '0;
         wcnt_q        <= '0;
         acc_q         <= '0;
         bias_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         wbuf_rd_en_q  <= 1'b0;
         wbuf_addr_q   <= '0;
         img_ready_q   <= 1'b0;
         pe_en_q       <= 1'b0;
         pe_exp_bias_q <= '0;
         pe_weight_q   <= '0;
         pe_image_q    <= '0;
         pe_psum_q     <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         wcnt_q        <= wcnt_d;
         acc_q         <= acc_d;
         bias_q        <= bias_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         wbuf_rd_en_q  <= wbuf_rd_en_d;
         wbuf_addr_q   <= wbuf_addr_d;
         img_ready_q   <= img_ready_d;
         pe_en_q       <= pe_en_d;
         pe_exp_bias_q <= pe_exp_bias_d;
         pe_weight_q   <= pe_weight_d;
         pe_image_q    <= pe_image_d;
         pe_psum_q     <= pe_psum_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.wbuf_rd_en  = wbuf_rd_en_q;
   assign bus.wbuf_addr   = wbuf_addr_q;
   assign bus.img_ready   = img_ready_q;
   assign bus.pe_en       = pe_en_q;
   assign bus.pe_exp_bias = pe_exp_bias_q;
   assign bus.pe_weight   = pe_weight_q;
   assign bus.pe_image    = pe_image_q;
   assign bus.pe_psum     = pe_psum_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: weight-buffer and PE models, a per-cycle monitor that
// tracks the job's running partial sum as plain arithmetic, and directed jobs
// with hand-computed results.
module tb_pe_seq_ctrl;
   localparam int IMG_W  = 24;
   localparam int WGT_W  = 36;
   localparam int PSUM_W = 16;
   localparam int EXP_W  = 5;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 8;
   localparam int PE_LAT = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_seq_ctrl_if #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .EXP_W(EXP_W),
                    .ADDR_W(ADDR_W), .CNT_W(CNT_W)) b ();

   pe_seq_ctrl #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .EXP_W(EXP_W),
                 .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PE_LAT(PE_LAT))
      dut (.clk(clk), .rst(rst), .bus(b));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // weight buffer: registered read, data valid the cycle after rd_en
   logic [WGT_W-1:0] wbuf [256];
   always @(posedge clk) if (b.wbuf_rd_en) b.wbuf_rdata <= wbuf[b.wbuf_addr];

   // PE model, PE_LAT=2: one register stage, psum_out = psum + image[15:0] + 1
   logic [PSUM_W-1:0] pe_r1 = '0;
   always @(posedge clk) pe_r1 <= b.pe_psum + b.pe_image[PSUM_W-1:0] + 16'd1;
   assign b.pe_psum_out = pe_r1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return {17'd0, b.busy, b.done, b.wbuf_rd_en, b.wbuf_addr, b.img_ready, b.pe_en,
              b.pe_exp_bias, b.pe_weight, b.pe_image, b.pe_psum, b.out_valid, b.out_data};
   endfunction

   // ---------------- monitor / model ----------------
   logic [PSUM_W-1:0] model_acc = '0;
   logic [WGT_W-1:0]  exp_wgt = '0;
   logic [EXP_W-1:0]  exp_bias = '0;
   logic              hs_prev = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
   logic [IMG_W-1:0]  hs_data = '0;
   int                done_cnt = 0, pe_en_cnt = 0, hs_n = 0;
   int                hs_cyc [512];

   // Sampled on the falling edge: launches, PE inputs after each handshake,
   // weight load, result value and done timing.
   always @(negedge clk) begin
      if (rst) begin
         hs_prev = 1'b0;
         prev_ov = 1'b0;
         prev_or = 1'b0;
      end else begin
         if (b.cfg_start && !b.busy) begin
            model_acc = b.cfg_psum_init;
            exp_wgt   = wbuf[b.cfg_wgt_addr];
            exp_bias  = b.cfg_exp_bias;
         end
         if (hs_prev) begin
            chk("pe_image", b.pe_image, hs_data);
            chk("pe_psum", b.pe_psum, model_acc);
            model_acc = model_acc + hs_data[PSUM_W-1:0] + 16'd1;
         end
         if (b.pe_en) begin
            pe_en_cnt++;
            chk("pe_weight", b.pe_weight, exp_wgt);
            chk("pe_exp_bias", b.pe_exp_bias, exp_bias);
         end
         if (b.out_valid) chk("out_data_model", b.out_data, model_acc);
         chk("done_timing", b.done, prev_ov && prev_or);
         if (b.done) done_cnt++;
         hs_prev = b.img_valid && b.img_ready;
         hs_data = b.img_data;
         if (hs_prev && hs_n < 512) begin
            hs_cyc[hs_n] = cyc;
            hs_n++;
         end
         prev_ov = b.out_valid;
         prev_or = b.out_ready;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] len,
                            input logic [EXP_W-1:0] bias, input logic [PSUM_W-1:0] init);
      b.cfg_wgt_addr  = addr;
      b.cfg_len       = len;
      b.cfg_exp_bias  = bias;
      b.cfg_psum_init = init;
      b.cfg_start     = 1'b1;
      tick();
      b.cfg_start     = 1'b0;
   endtask

   task automatic send_img(input logic [IMG_W-1:0] d, input int gap);
      int n = 0;
      b.img_valid = 1'b0;
      repeat (gap) tick();
      b.img_valid = 1'b1;
      b.img_data  = d;
      while (!b.img_ready && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL img_handshake: img_ready stayed 0 for %0d cycles, required 1", n);
      end
      tick();
      b.img_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!b.out_valid && n < 2000) begin
         tick();
         n++;
      end
      chk("wait_out_valid", b.out_valid, 1'b1);
   endtask

   task automatic accept();
      b.out_ready = 1'b1;
      tick();
      b.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int d0, p0, base, stable;
      rst = 1'b1;
      b.cfg_start = 1'b0; b.cfg_wgt_addr = '0; b.cfg_len = '0;
      b.cfg_exp_bias = '0; b.cfg_psum_init = '0;
      b.img_valid = 1'b0; b.img_data = '0; b.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) wbuf[i] = {4'hA, 24'(i * 7), 8'(i)};
      wbuf[3] = 36'h9C3_66C17E;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), '0);
      rst = 1'b0;
      tick();

      // T2 basic: read strobe, single weight latch, one image word
      p0 = pe_en_cnt;
      start_job(8'd3, 8'd1, 5'b11110, 16'h000F);
      chk("t2_rd_en", b.wbuf_rd_en, 1'b1);
      chk("t2_addr", b.wbuf_addr, 8'd3);
      chk("t2_busy", b.busy, 1'b1);
      tick();
      chk("t2_rd_en_off", b.wbuf_rd_en, 1'b0);
      tick();
      chk("t2_pe_en", b.pe_en, 1'b1);
      chk("t2_weight", b.pe_weight, 36'h9C3_66C17E);
      chk("t2_bias", b.pe_exp_bias, 5'b11110);
      send_img(24'h000100, 0);
      chk("t2_pe_psum", b.pe_psum, 16'h000F);
      chk("t2_pe_en_off", b.pe_en, 1'b0);
      wait_out();
      chk("t2_result", b.out_data, 16'h0110);  // 000F + 0100 + 1
      accept();
      chk("t2_done", b.done, 1'b1);
      chk("t2_out_valid_drop", b.out_valid, 1'b0);
      tick();
      chk("t2_done_once", b.done, 1'b0);
      chk("t2_pe_en_count", pe_en_cnt - p0, 1);

      // T3 accumulate, back-to-back words, out_ready already high
      b.out_ready = 1'b1;
      base = hs_n;
      start_job(8'd20, 8'd4, 5'd2, 16'h0000);
      for (int k = 0; k < 4; k++) send_img(24'h0, 0);
      wait_out();
      chk("t3_result", b.out_data, 16'h0004);
      tick();
      chk("t3_single_cycle_out", b.out_valid, 1'b0);
      chk("t3_done", b.done, 1'b1);
      b.out_ready = 1'b0;
      for (int k = 1; k < 4; k++)
         chk("t3_hs_spacing", hs_cyc[base+k] - hs_cyc[base+k-1], PE_LAT + 1);

      // T4 len=0 and T5 backpressure on the same job
      p0 = pe_en_cnt;
      start_job(8'd7, 8'd0, 5'd1, 16'h1234);
      chk("t4_no_ready_c1", b.img_ready, 1'b0);
      tick();
      chk("t4_no_ready_c2", b.img_ready, 1'b0);
      chk("t4_not_yet_valid", b.out_valid, 1'b0);
      tick();
      chk("t4_out_valid", b.out_valid, 1'b1);
      chk("t4_pe_en", b.pe_en, 1'b1);
      chk("t4_result", b.out_data, 16'h1234);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (b.out_valid && b.out_data == 16'h1234 && !b.img_ready && !b.done) stable++;
      end
      chk("t5_held_stable", stable, 10);
      d0 = done_cnt;
      accept();
      chk("t5_done", b.done, 1'b1);
      repeat (3) tick();
      chk("t5_done_count", done_cnt - d0, 1);
      chk("t4_pe_en_count", pe_en_cnt - p0, 1);

      // maximum length: no counter wrap
      b.out_ready = 1'b1;
      start_job(8'd10, 8'd255, 5'd3, 16'hFFF0);
      for (int i = 0; i < 255; i++) send_img(24'(i), 0);
      wait_out();
      chk("len255_result", b.out_data, 16'h7F70);  // FFF0 + 255*256/2
      tick();
      b.out_ready = 1'b0;
      tick();

      // T6 random gaps plus an ignored start pulse while busy
      d0 = done_cnt;
      start_job(8'd5, 8'd5, 5'd4, 16'h0100);
      for (int k = 0; k < 5; k++) begin
         send_img(24'(16 * (k + 1)), int'($urandom_range(0, 4)));
         if (k == 2) begin
            b.cfg_len = 8'd9;
            b.cfg_psum_init = 16'hDEAD;
            b.cfg_start = 1'b1;
            tick();
            b.cfg_start = 1'b0;
         end
      end
      wait_out();
      chk("t6_result", b.out_data, 16'h01F5);  // 0100 + F0 + 5
      accept();
      repeat (4) tick();
      chk("t6_idle_after", b.busy, 1'b0);
      chk("t6_done_count", done_cnt - d0, 1);

      // T1 reset in WAIT aborts the job; next job runs normally
      d0 = done_cnt;
      start_job(8'd3, 8'd3, 5'd0, 16'h0005);
      send_img(24'h000001, 0);
      #2 rst = 1'b1;
      #1;
      chk("t1_reset_outputs", outs(), '0);
      tick();
      tick();
      rst = 1'b0;
      stable = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!b.out_valid && !b.busy) stable++;
      end
      chk("t1_no_result", stable, 8);
      chk("t1_no_done", done_cnt - d0, 0);
      start_job(8'd3, 8'd2, 5'h0A, 16'h0005);
      send_img(24'h000001, 0);
      send_img(24'h000002, 0);
      wait_out();
      chk("t1_next_job", b.out_data, 16'h000A);  // 5 + 2 + 3
      accept();
      chk("t1_done", b.done, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
